// File: rtl/io_sequencer_if.sv
// io_sequencer_if: groups the host handshake, decompressor/DMA handshakes and the status
// outputs of io_sequencer into one bundle.
//   master : host/environment side (drives interrupt, load, cnn_img, done pulses, err_clr)
//   slave  : sequencer side (drives the enables, busy, load_done, error, chunk_count)
interface io_sequencer_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic             interrupt;
  logic             load;
  logic             cnn_img;
  logic             decompressor_done;
  logic             dma_done;
  logic             err_clr;
  logic             io_interface_en;
  logic             decompressor_en;
  logic             dma_enable;
  logic             busy;
  logic             load_done;
  logic             error;
  logic [CNT_W-1:0] chunk_count;

  modport master (
    output interrupt, load, cnn_img, decompressor_done, dma_done, err_clr,
    input  io_interface_en, decompressor_en, dma_enable, busy, load_done, error, chunk_count
  );

  modport slave (
    input  interrupt, load, cnn_img, decompressor_done, dma_done, err_clr,
    output io_interface_en, decompressor_en, dma_enable, busy, load_done, error, chunk_count
  );
endinterface

// File: rtl/io_sequencer.sv
// io_sequencer: sequences host transfers of compressed CNN weights (decompress then DMA, per
// chunk) and uncompressed images (DMA only) plus read-out through the I/O interface.
// A stall timeout in DECOMP/DMA drops the FSM into ERROR until err_clr.
// Ports:
//   clk    system clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    io_sequencer_if.slave: interrupt/load/cnn_img host request, decompressor_done,
//          dma_done, err_clr in; io_interface_en, decompressor_en, dma_enable, busy,
//          load_done, error, chunk_count out (all outputs are Moore decodes of the state)
module io_sequencer #(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned CNT_W          = 16,
  parameter int unsigned CNN_CHUNKS     = 4,
  parameter int unsigned IMG_CHUNKS     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input logic           clk,
  input logic           rst_n,
  io_sequencer_if.slave bus
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TimerW-1:0] TimerLast = TimerW'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CnnTarget = CNT_W'(CNN_CHUNKS);
  localparam logic [CNT_W-1:0] ImgTarget = CNT_W'(IMG_CHUNKS);

  typedef enum logic [2:0] {
    StIdle,
    StRead,
    StDecomp,
    StDma,
    StDone,
    StError
  } state_e;

  state_e              state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                int_s, int_s_q, start;
  logic                cnn_q, cnn_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [TimerW-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]    target;
  logic                enter;

  // Interrupt synchroniser and rising-edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      int_s_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.interrupt};
      int_s_q <= int_s;
    end
  end

  assign int_s  = sync_q[SYNC_STAGES-1];
  assign start  = int_s & ~int_s_q;
  assign target = cnn_q ? CnnTarget : ImgTarget;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnn_q   <= 1'b0;
      count_q <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      cnn_q   <= cnn_d;
      count_q <= count_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnn_d   = cnn_q;
    count_d = count_q;
    enter   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          enter = 1'b1;
          if (!bus.load) begin
            state_d = StRead;
          end else begin
            cnn_d   = bus.cnn_img;
            count_d = '0;
            state_d = bus.cnn_img ? StDecomp : StDma;
          end
        end
      end
      StRead: begin
        if (!int_s) begin
          state_d = StIdle;
          enter   = 1'b1;
        end
      end
      StDecomp: begin
        if (bus.decompressor_done) begin
          state_d = StDma;
          enter   = 1'b1;
        end else if (timer_q == TimerLast) begin
          state_d = StError;
          enter   = 1'b1;
        end
      end
      StDma: begin
        if (bus.dma_done) begin
          count_d = count_q + CNT_W'(1);
          enter   = 1'b1;
          // DMA->DMA for multi-chunk images is a re-entry and restarts the timer
          if (count_d == target) state_d = StDone;
          else                   state_d = cnn_q ? StDecomp : StDma;
        end else if (timer_q == TimerLast) begin
          state_d = StError;
          enter   = 1'b1;
        end
      end
      StDone: begin
        state_d = StIdle;
        enter   = 1'b1;
      end
      StError: begin
        if (bus.err_clr) begin
          state_d = StIdle;
          enter   = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        enter   = 1'b1;
      end
    endcase
  end

  // Timer only runs while waiting for a done; any state entry restarts it
  always_comb begin
    timer_d = '0;
    if (!enter && (state_q == StDecomp || state_q == StDma)) begin
      timer_d = timer_q + TimerW'(1);
    end
  end

  assign bus.io_interface_en = (state_q == StRead);
  assign bus.decompressor_en = (state_q == StDecomp);
  assign bus.dma_enable      = (state_q == StDma);
  assign bus.busy            = (state_q != StIdle);
  assign bus.load_done       = (state_q == StDone);
  assign bus.error           = (state_q == StError);
  assign bus.chunk_count     = count_q;

endmodule
